// File: rtl/grover_pkg.sv
// Shared types, widths and fixed-point helpers for the Grover search sequencer
// and its diffusion datapath.
package grover_pkg;

    localparam int NUM_BIT = 3;
    localparam int NUM_AMP = 1 << NUM_BIT;
    localparam int AMP_W   = 8;
    localparam int ACC_W   = 11;
    localparam int Q_FRAC  = 6;
    localparam int MAG_W   = AMP_W + 1;
    localparam int DIFF_W  = AMP_W + 2;
    localparam int IDX_W   = NUM_BIT;
    localparam int ITER_W  = 4;

    localparam logic signed [AMP_W-1:0] AMP_MAX = 8'sd127;
    localparam logic signed [AMP_W-1:0] AMP_MIN = -8'sd128;

    localparam logic signed [DIFF_W-1:0] SAT_HI = 10'sd127;
    localparam logic signed [DIFF_W-1:0] SAT_LO = -10'sd128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ORACLE,
        ST_SUM,
        ST_DIFFUSE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    function automatic logic signed [DIFF_W-1:0] sext_amp(input logic signed [AMP_W-1:0] a);
        return DIFF_W'(a);
    endfunction

    function automatic logic signed [AMP_W-1:0] sat_amp(input logic signed [DIFF_W-1:0] v);
        if (v > SAT_HI) begin
            return AMP_MAX;
        end else if (v < SAT_LO) begin
            return AMP_MIN;
        end
        return AMP_W'(v);
    endfunction

    // Magnitude is one bit wider so that |-128| = 128 stays representable.
    function automatic logic [MAG_W-1:0] abs_amp(input logic signed [AMP_W-1:0] a);
        logic signed [MAG_W-1:0] ext;
        ext = MAG_W'(a);
        return a[AMP_W-1] ? MAG_W'(-ext) : MAG_W'(ext);
    endfunction

endpackage

// File: rtl/grover_diffuse.sv
// Eight-lane inversion about the mean: each lane yields sat(2*mean - amp).
// When disabled the lanes pass their amplitude through unchanged.
module grover_diffuse
    import grover_pkg::*;
(
    input  logic                       en,
    input  logic [AMP_W-1:0]           mean,
    input  logic [NUM_AMP*AMP_W-1:0]   amp_in,
    output logic [NUM_AMP*AMP_W-1:0]   amp_out
);

    logic signed [DIFF_W-1:0] two_mean;

    assign two_mean = sext_amp($signed(mean)) <<< 1;

    generate
        for (genvar gi = 0; gi < NUM_AMP; gi++) begin : g_lane
            logic signed [AMP_W-1:0]  lane_amp;
            logic signed [DIFF_W-1:0] lane_diff;

            assign lane_amp  = $signed(amp_in[gi*AMP_W +: AMP_W]);
            assign lane_diff = two_mean - sext_amp(lane_amp);
            assign amp_out[gi*AMP_W +: AMP_W] = en ? sat_amp(lane_diff) : lane_amp;
        end
    endgenerate

endmodule

// File: rtl/grover_iter_ctrl.sv
// Sequencer for a 3-qubit Grover search: uniform load, ITERATIONS rounds of
// oracle + diffusion, then a largest-magnitude scan to pick the measured index.
module grover_iter_ctrl
    import grover_pkg::*;
#(
    parameter int INIT_AMP   = 23,
    parameter int ITERATIONS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       target,
    output logic             busy,
    output logic             done,
    output logic [3:0]       iter_cnt,
    output logic [7:0]       amp0,
    output logic [7:0]       amp1,
    output logic [7:0]       amp2,
    output logic [7:0]       amp3,
    output logic [7:0]       amp4,
    output logic [7:0]       amp5,
    output logic [7:0]       amp6,
    output logic [7:0]       amp7,
    output logic [2:0]       found_idx
);

    localparam logic [ITER_W:0]        ITER_LIM = (ITER_W+1)'(ITERATIONS);
    localparam logic signed [AMP_W-1:0] INIT_V  = AMP_W'(INIT_AMP);
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_AMP - 1);

    state_t                   state_q, state_d;
    logic signed [AMP_W-1:0]  amp_q [NUM_AMP];
    logic signed [AMP_W-1:0]  amp_d [NUM_AMP];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [ITER_W-1:0]        iter_q, iter_d;
    logic [IDX_W-1:0]         target_q, target_d;
    logic [MAG_W-1:0]         best_mag_q, best_mag_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic [IDX_W-1:0]         found_q, found_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     diff_en;
    logic signed [AMP_W-1:0]  mean;
    logic [NUM_AMP*AMP_W-1:0] amp_flat;
    logic [NUM_AMP*AMP_W-1:0] diff_flat;
    logic signed [AMP_W-1:0]  diff_amp [NUM_AMP];
    logic signed [AMP_W-1:0]  cur_amp;
    logic [MAG_W-1:0]         cur_mag;
    logic                     cur_take;

    // Arithmetic shift gives the floor of acc/8, as the diffusion mean requires.
    assign mean = AMP_W'(acc_q >>> NUM_BIT);

    generate
        for (genvar gi = 0; gi < NUM_AMP; gi++) begin : g_flat
            assign amp_flat[gi*AMP_W +: AMP_W] = amp_q[gi];
            assign diff_amp[gi] = $signed(diff_flat[gi*AMP_W +: AMP_W]);
        end
    endgenerate

    grover_diffuse u_diffuse (
        .en      (diff_en),
        .mean    (mean),
        .amp_in  (amp_flat),
        .amp_out (diff_flat)
    );

    assign cur_amp  = amp_q[idx_q];
    assign cur_mag  = abs_amp(cur_amp);
    // The first lane seeds the scan; later lanes win only when strictly larger.
    assign cur_take = (idx_q == '0) || (cur_mag > best_mag_q);

    always_comb begin
        state_d    = state_q;
        amp_d      = amp_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        iter_d     = iter_q;
        target_d   = target_q;
        best_mag_d = best_mag_q;
        best_idx_d = best_idx_q;
        found_d    = found_q;
        diff_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    target_d = target;
                    iter_d   = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                for (int i = 0; i < NUM_AMP; i++) begin
                    amp_d[i] = INIT_V;
                end
                idx_d   = '0;
                state_d = (ITER_LIM != '0) ? ST_ORACLE : ST_MEASURE;
            end
            ST_ORACLE: begin
                amp_d[target_q] = sat_amp(-sext_amp(amp_q[target_q]));
                acc_d   = '0;
                idx_d   = '0;
                state_d = ST_SUM;
            end
            ST_SUM: begin
                acc_d = acc_q + ACC_W'(cur_amp);
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DIFFUSE;
                end
            end
            ST_DIFFUSE: begin
                diff_en = 1'b1;
                amp_d   = diff_amp;
                iter_d  = iter_q + 1'b1;
                idx_d   = '0;
                state_d = ({1'b0, iter_q} + 1'b1 < ITER_LIM) ? ST_ORACLE : ST_MEASURE;
            end
            ST_MEASURE: begin
                if (cur_take) begin
                    best_mag_d = cur_mag;
                    best_idx_d = idx_q;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    found_d = cur_take ? idx_q : best_idx_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < NUM_AMP; i++) begin
                amp_q[i] <= '0;
            end
            acc_q      <= '0;
            idx_q      <= '0;
            iter_q     <= '0;
            target_q   <= '0;
            best_mag_q <= '0;
            best_idx_q <= '0;
            found_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            for (int i = 0; i < NUM_AMP; i++) begin
                amp_q[i] <= amp_d[i];
            end
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            iter_q     <= iter_d;
            target_q   <= target_d;
            best_mag_q <= best_mag_d;
            best_idx_q <= best_idx_d;
            found_q    <= found_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign iter_cnt  = iter_q;
    assign found_idx = found_q;
    assign amp0      = amp_q[0];
    assign amp1      = amp_q[1];
    assign amp2      = amp_q[2];
    assign amp3      = amp_q[3];
    assign amp4      = amp_q[4];
    assign amp5      = amp_q[5];
    assign amp6      = amp_q[6];
    assign amp7      = amp_q[7];

endmodule

// File: tb/tb_grover_iter_ctrl.sv
// Runs four differently parameterised controllers side by side on random
// targets and compares them against an integer model of Grover's algorithm.
module tb_grover_iter_ctrl;

    localparam int NI = 4;
    localparam int INIT_TAB [NI] = '{23, 23, 23, 100};
    localparam int ITER_TAB [NI] = '{2, 1, 0, 1};
    localparam int LAST_N = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NI-1:0]           start_w;
    logic [2:0]              target;
    logic [NI-1:0]           busy_w;
    logic [NI-1:0]           done_w;
    logic [3:0]              iter_w  [NI];
    logic [2:0]              found_w [NI];
    logic signed [7:0]       amp_w   [NI][8];

    int n_checks = 0;
    int n_errors = 0;

    int mdl_amp   [NI][3][8];
    int mdl_found [NI];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            grover_iter_ctrl #(
                .INIT_AMP   (INIT_TAB[gi]),
                .ITERATIONS (ITER_TAB[gi])
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .start     (start_w[gi]),
                .target    (target),
                .busy      (busy_w[gi]),
                .done      (done_w[gi]),
                .iter_cnt  (iter_w[gi]),
                .amp0      (amp_w[gi][0]),
                .amp1      (amp_w[gi][1]),
                .amp2      (amp_w[gi][2]),
                .amp3      (amp_w[gi][3]),
                .amp4      (amp_w[gi][4]),
                .amp5      (amp_w[gi][5]),
                .amp6      (amp_w[gi][6]),
                .amp7      (amp_w[gi][7]),
                .found_idx (found_w[gi])
            );
        end
    endgenerate

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_amp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int floor_div8(input int s);
        if (s >= 0) return s / 8;
        return -((-s + 7) / 8);
    endfunction

    task automatic build_model(input int tgt);
        int a [8];
        int s, m, best, mag;
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < 8; j++) begin
                a[j] = INIT_TAB[i];
                mdl_amp[i][0][j] = a[j];
            end
            for (int r = 1; r <= ITER_TAB[i]; r++) begin
                a[tgt] = clamp_amp(-a[tgt]);
                s = 0;
                for (int j = 0; j < 8; j++) s += a[j];
                m = floor_div8(s);
                for (int j = 0; j < 8; j++) begin
                    a[j] = clamp_amp(2 * m - a[j]);
                    mdl_amp[i][r][j] = a[j];
                end
            end
            best = -1;
            mdl_found[i] = 0;
            for (int j = 0; j < 8; j++) begin
                mag = (a[j] < 0) ? -a[j] : a[j];
                if (mag > best) begin
                    best = mag;
                    mdl_found[i] = j;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("%s_i%0d_busy", tag, i), int'(busy_w[i]), 0);
            check_val($sformatf("%s_i%0d_done", tag, i), int'(done_w[i]), 0);
            check_val($sformatf("%s_i%0d_iter", tag, i), int'(iter_w[i]), 0);
            check_val($sformatf("%s_i%0d_found", tag, i), int'(found_w[i]), 0);
            for (int j = 0; j < 8; j++) begin
                check_val($sformatf("%s_i%0d_amp%0d", tag, i, j), int'(amp_w[i][j]), 0);
            end
        end
    endtask

    task automatic check_amps(input string tag, input int i, input int r);
        for (int j = 0; j < 8; j++) begin
            check_val($sformatf("%s_i%0d_amp%0d", tag, i, j), int'(amp_w[i][j]), mdl_amp[i][r][j]);
        end
    endtask

    // n counts cycles after the accept edge: LOAD is n=1, done at n=10+10*ITERATIONS.
    task automatic run_job(input int tgt, input bit noise, input int abort_n);
        int dn;
        int errs_before;
        errs_before = n_errors;
        build_model(tgt);
        @(negedge clk);
        target  = 3'(tgt);
        start_w = '1;
        @(negedge clk);
        start_w = '0;
        for (int n = 1; n <= LAST_N; n++) begin
            if (n == abort_n) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check_all_zero("rst_mid");
                $display("job target=%0d noise=%0d aborted at n=%0d errors=%0d",
                         tgt, noise, n, n_errors - errs_before);
                return;
            end
            for (int i = 0; i < NI; i++) begin
                dn = 10 + 10 * ITER_TAB[i];
                check_val($sformatf("i%0d_busy_n%0d", i, n), int'(busy_w[i]), (n <= dn) ? 1 : 0);
                check_val($sformatf("i%0d_done_n%0d", i, n), int'(done_w[i]), (n == dn) ? 1 : 0);
                for (int k = 0; k < ITER_TAB[i]; k++) begin
                    if (n == 12 + 10 * k) begin
                        check_val($sformatf("i%0d_iter_r%0d", i, k + 1), int'(iter_w[i]), k + 1);
                        check_amps($sformatf("round%0d", k + 1), i, k + 1);
                    end
                end
                if (n == dn || n == LAST_N) begin
                    check_val($sformatf("i%0d_found_n%0d", i, n), int'(found_w[i]), mdl_found[i]);
                    check_val($sformatf("i%0d_iterfin_n%0d", i, n), int'(iter_w[i]), ITER_TAB[i]);
                    check_amps($sformatf("final_n%0d", n), i, ITER_TAB[i]);
                end
            end
            if (noise && (n == 4 || n == 14)) begin
                start_w[0] = 1'b1;
                target     = 3'd3;
            end else begin
                start_w[0] = 1'b0;
            end
            @(negedge clk);
        end
        $display("job target=%0d noise=%0d found=%0d/%0d/%0d/%0d errors=%0d",
                 tgt, noise, found_w[0], found_w[1], found_w[2], found_w[3],
                 n_errors - errs_before);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_w = '0;
        target  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("por");
        rst_n = 1'b1;

        run_job(5, 1'b0, 0);
        check_val("spec_t5_amp5", int'(amp_w[0][5]), 61);
        check_val("spec_t5_amp0", int'(amp_w[0][0]), -7);
        check_val("spec_t5_found", int'(found_w[0]), 5);
        check_val("spec_it1_amp5", int'(amp_w[1][5]), 57);
        check_val("spec_it1_amp1", int'(amp_w[1][1]), 11);
        check_val("spec_it0_amp3", int'(amp_w[2][3]), 23);
        check_val("spec_it0_found", int'(found_w[2]), 0);

        run_job(0, 1'b0, 0);
        check_val("spec_t0_amp0", int'(amp_w[0][0]), 61);
        check_val("spec_t0_amp7", int'(amp_w[0][7]), -7);

        run_job(2, 1'b0, 0);
        check_val("spec_sat_amp2", int'(amp_w[3][2]), 127);
        check_val("spec_sat_amp4", int'(amp_w[3][4]), 50);

        run_job(5, 1'b1, 0);
        check_val("spec_noise_amp5", int'(amp_w[0][5]), 61);

        run_job(3, 1'b0, 6);
        run_job(7, 1'b0, 0);
        check_val("spec_t7_it1_amp7", int'(amp_w[1][7]), 57);

        for (int r = 0; r < 10; r++) begin
            run_job(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/grover_iter_ctrl.md
# grover_iter_ctrl

Sequential controller that runs a complete Grover search over a 3-qubit (8-amplitude) state vector held in signed Q1.6 fixed point. On a start handshake it loads a uniform superposition, then runs ITERATIONS rounds of oracle (negate the target amplitude) followed by diffusion (inversion about the mean). It then scans for the largest-magnitude amplitude and reports it as the measured index. It sits above the amplitude datapath as its sequencer, owning the amplitude register bank and the iteration schedule.

## Interface
- NUM_BIT, 3, qubits; the state vector has 2**NUM_BIT = 8 amplitudes.
- AMP_W, 8, amplitude width, signed Q1.6 (value/64).
- INIT_AMP, 23, uniform load value (about 1/sqrt(8)).
- ITERATIONS, 2, Grover rounds, legal range 0..15.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- target  in  3  index to mark; latched on accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- iter_cnt  out  4  completed rounds.
- amp0..amp7  out  8 each  signed amplitude registers.
- found_idx  out  3  measured index, valid from done onward.

## Operation
- States: IDLE, LOAD, ORACLE, SUM, DIFFUSE, MEASURE, DONE.
- IDLE, start=1: latch target, clear iter_cnt, go to LOAD.
- LOAD: all amps = INIT_AMP. Go to ORACLE if ITERATIONS>0, else MEASURE.
- ORACLE (1 cycle): amp[target] = -amp[target]. -128 negates to 127 (saturating).
- SUM (8 cycles): idx counts 0..7. 11-bit signed acc += amp[idx]; acc is cleared on SUM entry.
- DIFFUSE (1 cycle):
  - mean = acc >>> 3 (arithmetic shift, floor).
  - Each amp = 2*mean - amp, computed at 10 bits and saturated to [-128,127].
  - iter_cnt increments. Go to ORACLE if iter_cnt+1 < ITERATIONS, else MEASURE.
- MEASURE (8 cycles): scan idx 0..7 on |amp| (9-bit, |-128|=128). Only a strictly greater value replaces the best, so ties keep the lowest index. found_idx is written at the end of the scan.
- DONE (1 cycle): done=1, then IDLE.
- start or target changes while busy are ignored. Amps, found_idx and iter_cnt hold until the next accept.
- rst_n=0 at any edge, in any state: state=IDLE; all amps, found_idx, iter_cnt, done, busy and acc become 0. This takes priority over start.

## Timing
- Accept at edge t:
  - LOAD at t+1.
  - Round k (k = 0..ITERATIONS-1): ORACLE at t+2+10k, SUM at t+3+10k..t+10+10k, DIFFUSE at t+11+10k.
  - MEASURE spans 8 cycles, then DONE.
  - done is high during cycle t+10+10*ITERATIONS (t+30 at the default).
- All outputs are registered; no combinational input-to-output path.
- busy rises in the cycle after the accept edge and falls in the cycle after DONE.
- A new start is accepted in the first IDLE cycle after DONE.

## Structure
- Package grover_pkg holds:
  - the state enum;
  - NUM_BIT, AMP_W, ACC_W=11, Q_FRAC=6;
  - the saturation limits AMP_MAX=127 and AMP_MIN=-128.
- Sub-module grover_diffuse: a combinational 8-lane block taking mean and amp0..7 and producing saturated 2*mean - amp. It is instantiated once and enabled in DIFFUSE.

## Test plan
- Defaults, target=5, start at t:
  - after round 1: amp5=57, others 11;
  - final: amp5=61, others -7;
  - found_idx=5, done pulse at t+30, busy low at t+31.
- Defaults, target=0: final amp0=61, amp1..7=-7; found_idx=0.
- ITERATIONS=1, target=7: amp7=57, others 11; found_idx=7; done at t+20.
- ITERATIONS=0: all amps 23; found_idx=0 (tie rule); done at t+10.
- INIT_AMP=100, ITERATIONS=1, target=2: sum=600, mean=75; amp2 saturates to 127, others 50.
- Robustness:
  - start with target=3 pulsed at t+5 and t+15 during a target=5 run: no effect; result still 61 at index 5.
  - rst_n low during SUM: next cycle all outputs 0, busy 0; a following start completes normally.
